spi_slave_regs: RTL

SPI slave register file that sits directly downstream of the Wishbone-to-SPI bridge. It is the device at the far end of `spi_mosi`/`spi_sck`/`spi_ss`/`spi_miso`. It oversamples the SPI pins in the system clock domain, decodes a command/data byte protocol, and exposes three 8-bit read/write control registers plus one read-only status register to local logic. It is used both as a synthesizable peripheral and as the bridge's closed-loop test target.

---
 rtl/spi_slave_regs.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_regs.sv
//------------------------------------------------------------------------------
// spi_slave_regs
//
// SPI (mode 0) slave register file. The SPI pins are oversampled in the system
// clock domain, and a command/data byte protocol is decoded:
//   byte 0    : command. bit7 = 1 write / 0 read, bits1:0 = start address.
//   bytes 1..N: data. The address advances after every data byte, modulo 4.
// Three 8-bit read/write control registers (addresses 0..2) are exposed on
// 'ctrl'. Address 3 is read-only and returns 'status_in'.
//
// Parameters:
//   CLK_PER_SCK_MIN : minimum clk/SCK ratio the design supports. It is used
//                     only by a simulation assertion on the SCK edge spacing.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-low
//   spi_sck      in   serial clock, mode 0 (idle low)
//   spi_mosi     in   master out slave in, MSB first
//   spi_ss       in   slave select, active-low
//   spi_miso     out  master in slave out, always driven, 0 when not selected
//   status_in    in   value returned for register 3
//   ctrl         out  {reg2, reg1, reg0}
//   wr_stb       out  one-cycle pulse per completed data byte of a write frame
//   wr_addr      out  register address of that byte
//   wr_data      out  data byte
//   frame_active out  high while a frame is in progress
//------------------------------------------------------------------------------
module spi_slave_regs #(
  parameter int CLK_PER_SCK_MIN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_ss,
  output logic        spi_miso,
  input  logic [7:0]  status_in,
  output logic [23:0] ctrl,
  output logic        wr_stb,
  output logic [1:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Minimum number of clk cycles between two detected SCK edges inside a frame.
  localparam logic [7:0] GAP_MIN = 8'(CLK_PER_SCK_MIN / 2);

  // Synchronizer chains: [0] and [1] are the two synchronizing flops, [2] is
  // the history flop used for edge detection.
  logic [2:0] r_sck_sync;
  logic [2:0] r_ss_sync;
  logic [1:0] r_mosi_sync;

  state_t     r_state;
  state_t     w_state_next;

  logic [2:0] r_bit_cnt;
  logic [1:0] r_addr;
  logic       r_is_write;
  logic [7:0] r_rx_sh;
  logic [7:0] r_tx_sh;
  logic       r_miso;

  logic       r_wr_stb;
  logic [1:0] r_wr_addr;
  logic [7:0] r_wr_data;

  logic [7:0] r_reg0;
  logic [7:0] r_reg1;
  logic [7:0] r_reg2;

  logic [7:0] r_sck_gap;

  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_ss_rise;
  logic       w_ss_fall;
  logic       w_mosi;
  logic       w_in_frame;
  logic       w_sck_rise_act;
  logic       w_sck_fall_act;
  logic       w_byte_done;
  logic [7:0] w_rx_byte;
  logic [7:0] w_reg_sel;

  // Pin synchronization. Slave select idles high, so its chain resets to 1s;
  // that way reset release with the slave deselected never looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sck_sync  <= 3'b000;
      r_ss_sync   <= 3'b111;
      r_mosi_sync <= 2'b00;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], spi_sck};
      r_ss_sync   <= {r_ss_sync[1:0], spi_ss};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
    end
  end

  assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
  assign w_ss_rise  = r_ss_sync[1] & ~r_ss_sync[2];
  assign w_ss_fall  = ~r_ss_sync[1] & r_ss_sync[2];
  assign w_mosi     = r_mosi_sync[1];

  // SCK edges only count inside a frame, and a simultaneous slave-select rise
  // takes priority so the edge is dropped.
  assign w_in_frame     = (r_state != IDLE);
  assign w_sck_rise_act = w_in_frame & w_sck_rise & ~w_ss_rise;
  assign w_sck_fall_act = w_in_frame & w_sck_fall & ~w_ss_rise;
  assign w_byte_done    = w_sck_rise_act & (r_bit_cnt == 3'd7);
  assign w_rx_byte      = {r_rx_sh[6:0], w_mosi};

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: a slave-select rise returns to IDLE from anywhere; the
  // command byte completing moves CMD to DATA, where the frame then stays.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_ss_fall && !w_ss_rise) begin
          w_state_next = CMD;
        end
      end
      CMD: begin
        if (w_ss_rise) begin
          w_state_next = IDLE;
        end else if (w_byte_done) begin
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_ss_rise) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Byte returned for the current address; address 3 reads the live status.
  always_comb begin
    w_reg_sel = status_in;
    case (r_addr)
      2'd0:    w_reg_sel = r_reg0;
      2'd1:    w_reg_sel = r_reg1;
      2'd2:    w_reg_sel = r_reg2;
      default: w_reg_sel = status_in;
    endcase
  end

  // Frame datapath: receive shifter, bit counter, address pointer, transmit
  // shifter and the write strobe. The address is advanced in the same cycle
  // the byte completes; the strobe carries the pre-increment address so the
  // register write one cycle later lands in the right place. The transmit
  // shifter reloads on the SCK fall that follows a completed byte, which is
  // after the address has already moved on, so each data byte returns the
  // addressed register before any write to it takes effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt  <= 3'd0;
      r_addr     <= 2'd0;
      r_is_write <= 1'b0;
      r_rx_sh    <= 8'd0;
      r_tx_sh    <= 8'd0;
      r_wr_stb   <= 1'b0;
      r_wr_addr  <= 2'd0;
      r_wr_data  <= 8'd0;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_ss_rise) begin
        r_bit_cnt <= 3'd0;
        r_addr    <= 2'd0;
      end else if (!w_in_frame) begin
        if (w_ss_fall) begin
          r_tx_sh   <= status_in;
          r_bit_cnt <= 3'd0;
          r_addr    <= 2'd0;
        end
      end else if (w_sck_rise_act) begin
        r_rx_sh   <= w_rx_byte;
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (w_byte_done) begin
          if (r_state == CMD) begin
            r_is_write <= w_rx_byte[7];
            r_addr     <= w_rx_byte[1:0];
          end else begin
            if (r_is_write) begin
              r_wr_stb  <= 1'b1;
              r_wr_addr <= r_addr;
              r_wr_data <= w_rx_byte;
            end
            r_addr <= r_addr + 2'd1;
          end
        end
      end else if (w_sck_fall_act) begin
        if (r_bit_cnt == 3'd0) begin
          r_tx_sh <= w_reg_sel;
        end else begin
          r_tx_sh <= {r_tx_sh[6:0], 1'b0};
        end
      end
    end
  end

  // Register file update, one cycle after the strobe. Address 3 is read-only,
  // so a strobe there is reported but changes nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg0 <= 8'd0;
      r_reg1 <= 8'd0;
      r_reg2 <= 8'd0;
    end else if (r_wr_stb) begin
      case (r_wr_addr)
        2'd0:    r_reg0 <= r_wr_data;
        2'd1:    r_reg1 <= r_wr_data;
        2'd2:    r_reg2 <= r_wr_data;
        default: begin
        end
      endcase
    end
  end

  // MISO is registered so it never glitches; it follows the transmit
  // shifter's MSB while selected and is forced low otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miso <= 1'b0;
    end else begin
      r_miso <= w_in_frame ? r_tx_sh[7] : 1'b0;
    end
  end

  // Spacing monitor for SCK edges: counts clk cycles since the previous
  // detected edge (saturating) and flags edges arriving faster than the
  // synchronizer and transmit path can follow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sck_gap <= 8'hFF;
    end else begin
      if (w_sck_rise || w_sck_fall) begin
        r_sck_gap <= 8'd1;
        if (w_in_frame && !w_ss_rise) begin
          assert (r_sck_gap >= GAP_MIN);
        end
      end else if (r_sck_gap != 8'hFF) begin
        r_sck_gap <= r_sck_gap + 8'd1;
      end
    end
  end

  assign spi_miso     = r_miso;
  assign ctrl         = {r_reg2, r_reg1, r_reg0};
  assign wr_stb       = r_wr_stb;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign frame_active = w_in_frame;

endmodule
